boron_key_ctrl: RTL and testbench
=================================

# boron_key_ctrl

Sequencer for the BORON 80-bit key schedule. It latches a master key on a start request and walks round counter 1..25 through a single-round key update. It streams the 26 round keys RK0..RK25 (64 LSBs of the key register) to the round datapath over a valid/ready handshake, then signals completion. It sits between the top-level cipher FSM and the round function.

## Interface
- NUM_ROUNDS, 25, number of key updates; RK0..RK[NUM_ROUNDS] are emitted
- KEY_W, 80, key register width
- RK_W, 64, round-key width (key register bits [RK_W-1:0])
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_start  in  1  start request, sampled only in IDLE
- i_key  in  KEY_W  master key, sampled on the accepted i_start
- o_busy  out  1  high in EMIT and DONE
- o_rk_valid  out  1  round key available
- i_rk_ready  in  1  round datapath accepts key
- o_rk  out  RK_W  current round key
- o_rk_idx  out  5  index of o_rk (0..NUM_ROUNDS)
- o_rk_last  out  1  high with valid when o_rk_idx==NUM_ROUNDS
- o_done  out  1  one-cycle pulse after the last key is accepted

## Operation
- States: IDLE, EMIT, DONE.
- IDLE:
  - i_start=1: key_reg<=i_key, idx<=0, go to EMIT.
  - Otherwise hold.
- EMIT:
  - o_rk_valid=1, o_rk=key_reg[63:0], o_rk_idx=idx, o_rk_last=(idx==NUM_ROUNDS).
  - On valid&ready with idx<NUM_ROUNDS: key_reg<=ks_round(key_reg, idx+1), idx<=idx+1.
  - On valid&ready with idx==NUM_ROUNDS: go to DONE, key_reg unchanged.
- DONE: o_done=1 for exactly one cycle, then IDLE.
- ks_round(K, rc), rc 5-bit:
  - K'=K<<<13 over 80 bits.
  - K'[3:0]=S(K'[3:0]).
  - K'[63:59]^=rc.
- S-box: {E,4,B,1,7,9,C,A,D,2,0,F,8,5,3,6}, indexed by input nibble.
- i_start outside IDLE is ignored; there is no queueing.
- i_key changes after acceptance have no effect.

## Timing
- Reset (rst=0, asynchronous):
  - State IDLE; key_reg=0, idx=0.
  - All outputs 0: o_busy, o_rk_valid, o_rk, o_rk_idx, o_rk_last, o_done.
- All outputs are registered or decoded from state/key_reg only. There is no combinational path from i_rk_ready to any output.
- i_start accepted at edge N: o_rk_valid rises after N, with RK0 visible in cycle N+1.
- With i_rk_ready held high, RKk is visible in cycle N+1+k. RK25 is in N+26, o_done is in N+27, and state is IDLE from N+28. A new i_start is accepted at the N+28 edge at the earliest.
- Backpressure: while valid&!ready, o_rk, o_rk_idx and o_rk_last stay stable and valid stays high. Ready may toggle arbitrarily.
- Ready high during IDLE or DONE has no effect.
- Reset asserted mid-EMIT: immediate return to IDLE and zeroed outputs. No o_done is produced for the aborted run.
- idx never exceeds NUM_ROUNDS; no wrap-around of the 5-bit counter.

## Structure
- Shared package boron_pkg holds:
  - KEY_W, RK_W and NUM_ROUNDS constants.
  - The 16-entry S-box constant.
  - The state enum {IDLE, EMIT, DONE}.
- One combinational sub-module boron_ks_round (inputs: 80-bit key, 5-bit rc; output: 80-bit next key) implements ks_round. It is reusable by a decryption-side key unroller.
- Controller body: FSM, key_reg, idx and output decode only.

## Test plan
- Reset, then rst=1 with no start: all outputs 0 for 10 cycles; i_rk_ready=1 produces nothing.
- i_key=0, i_start for 1 cycle, ready=1:
  - RK0=64'h0 at idx 0.
  - RK1=64'h0800_0000_0000_000E at idx 1.
  - 26 valids total, o_rk_last only on idx 25.
  - o_done one cycle at N+27.
- Same key with ready toggled by a random 50% pattern: the identical 26-key sequence arrives in order, and o_rk is stable during every stall cycle.
- i_start pulsed again at idx 10 with a different i_key: ignored, and the sequence continues from the original key.
- rst asserted while idx=12, then released and a start issued with key 80'hFFFF_FFFF_FFFF_FFFF_FFFF: outputs are zero during reset, no o_done is produced, and the fresh run begins with RK0=64'hFFFF_FFFF_FFFF_FFFF.
- Back-to-back runs, i_start held high continuously: the second run's RK0 appears exactly one cycle after the IDLE cycle following o_done, and each run yields 26 keys.

Source files
------------

// File: rtl/boron_pkg.sv
// Shared constants, S-box and FSM state type for the BORON key schedule.
// Imported by the key-schedule interface, round update and sequencer.
package boron_pkg;

    localparam int KEY_W = 80;
    localparam int RK_W  = 64;
    localparam int IDX_W = 5;

    localparam logic [IDX_W-1:0] NUM_ROUNDS = 5'd25;

    // Nibble i of this word is S(i): {E,4,B,1,7,9,C,A,D,2,0,F,8,5,3,6}
    localparam logic [63:0] SBOX = 64'h6358_F02D_AC97_1B4E;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [3:0] sbox(input logic [3:0] n);
        return SBOX[{n, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/boron_key_if.sv
// Start/key request and round-key valid/ready stream of the key sequencer.
// master: sequencer side; slave: cipher FSM / round datapath side.
interface boron_key_if;
    import boron_pkg::*;

    logic                 i_start;
    logic [KEY_W-1:0]     i_key;
    logic                 o_busy;
    logic                 o_rk_valid;
    logic                 i_rk_ready;
    logic [RK_W-1:0]      o_rk;
    logic [IDX_W-1:0]     o_rk_idx;
    logic                 o_rk_last;
    logic                 o_done;

    modport master (
        input  i_start, i_key, i_rk_ready,
        output o_busy, o_rk_valid, o_rk, o_rk_idx, o_rk_last, o_done
    );

    modport slave (
        output i_start, i_key, i_rk_ready,
        input  o_busy, o_rk_valid, o_rk, o_rk_idx, o_rk_last, o_done
    );

endinterface

// File: rtl/boron_ks_round.sv
// One BORON key-schedule update: rotate left 13, S-box low nibble, xor rc.
// Ports: i_key (80b current key), i_rc (5b round counter), o_key (next key).
module boron_ks_round
    import boron_pkg::*;
(
    input  logic [KEY_W-1:0] i_key,
    input  logic [IDX_W-1:0] i_rc,
    output logic [KEY_W-1:0] o_key
);

    logic [KEY_W-1:0] w_rot;

    assign w_rot = {i_key[KEY_W-14:0], i_key[KEY_W-1:KEY_W-13]};

    always_comb begin
        o_key        = w_rot;
        o_key[3:0]   = sbox(w_rot[3:0]);
        o_key[63:59] = w_rot[63:59] ^ i_rc;
    end

endmodule

// File: rtl/boron_key_ctrl.sv
// BORON key-schedule sequencer: latches a master key, streams RK0..RK25.
// Ports: clk, rst (async active-low), bus (boron_key_if.master).
module boron_key_ctrl
    import boron_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    boron_key_if.master bus
);

    state_t           r_state;
    logic [KEY_W-1:0] r_key;
    logic [IDX_W-1:0] r_idx;

    logic [IDX_W-1:0] w_rc;
    logic [KEY_W-1:0] w_next_key;
    logic             w_emit;

    assign w_rc = r_idx + 5'd1;

    boron_ks_round u_round (
        .i_key (r_key),
        .i_rc  (w_rc),
        .o_key (w_next_key)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_key   <= '0;
            r_idx   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.i_start) begin
                        r_key   <= bus.i_key;
                        r_idx   <= '0;
                        r_state <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.i_rk_ready) begin
                        if (r_idx == NUM_ROUNDS) begin
                            r_state <= DONE;
                        end else begin
                            r_key <= w_next_key;
                            r_idx <= w_rc;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode from state and registers only; ready never reaches them.
    assign w_emit         = (r_state == EMIT);
    assign bus.o_busy     = (r_state != IDLE);
    assign bus.o_rk_valid = w_emit;
    assign bus.o_rk       = w_emit ? r_key[RK_W-1:0] : '0;
    assign bus.o_rk_idx   = w_emit ? r_idx : '0;
    assign bus.o_rk_last  = w_emit && (r_idx == NUM_ROUNDS);
    assign bus.o_done     = (r_state == DONE);

endmodule

// File: tb/tb_boron_key_ctrl.sv
// Scoreboard bench for boron_key_ctrl: stimulus queues expected keys,
// a negedge monitor pops and compares on every accepted key and done.
module tb_boron_key_ctrl;
    import boron_pkg::*;

    typedef struct {
        bit          is_done;
        logic [4:0]  idx;
        logic [63:0] rk;
        bit          last;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t q[$];

    logic [3:0] sb_t [16] = '{4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
                              4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6};

    boron_key_if bus();

    boron_key_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [79:0] act,
                       input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [79:0] m_round(input logic [79:0] k,
                                             input logic [4:0] rc);
        logic [79:0] t;
        t = k;
        for (int i = 0; i < 13; i++) t = {t[78:0], t[79]};
        t[3:0] = sb_t[t[3:0]];
        t[63:59] = t[63:59] ^ rc;
        return t;
    endfunction

    task automatic push_run(input logic [79:0] key);
        exp_t e;
        logic [79:0] k;
        k = key;
        for (int i = 0; i <= 25; i++) begin
            e.is_done = 1'b0;
            e.idx = i[4:0];
            e.rk = k[63:0];
            e.last = (i == 25);
            q.push_back(e);
            if (i < 25) k = m_round(k, 5'(i + 1));
        end
        e.is_done = 1'b1;
        e.idx = '0;
        e.rk = '0;
        e.last = 1'b0;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [79:0] key);
        bus.i_key = key;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (!bus.o_done && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_idx(input logic [4:0] target, input int max,
                            input string name);
        int n;
        n = 0;
        while (bus.o_rk_idx !== target && n < max) begin
            tick();
            n++;
        end
        chk(name, bus.o_rk_idx, target);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_busy"}, bus.o_busy, 0);
        chk({name, "_valid"}, bus.o_rk_valid, 0);
        chk({name, "_rk"}, bus.o_rk, 0);
        chk({name, "_idx"}, bus.o_rk_idx, 0);
        chk({name, "_last"}, bus.o_rk_last, 0);
        chk({name, "_done"}, bus.o_done, 0);
    endtask

    // Monitor: scoreboard pops plus stall-stability checks.
    initial begin
        exp_t        e;
        bit          st_prev;
        logic [63:0] p_rk;
        logic [4:0]  p_idx;
        logic        p_last;
        st_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (st_prev) begin
                    chk("stall_valid", bus.o_rk_valid, 1);
                    chk("stall_rk", bus.o_rk, p_rk);
                    chk("stall_idx", bus.o_rk_idx, p_idx);
                    chk("stall_last", bus.o_rk_last, p_last);
                end
                if (bus.o_rk_valid && bus.i_rk_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected_key idx=%0d",
                                 bus.o_rk_idx);
                    end else begin
                        e = q.pop_front();
                        chk("sb_kind_key", e.is_done, 0);
                        chk("sb_idx", bus.o_rk_idx, e.idx);
                        chk("sb_rk", bus.o_rk, e.rk);
                        chk("sb_last", bus.o_rk_last, e.last);
                    end
                end
                if (bus.o_done) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected_done act=1 exp=0");
                    end else begin
                        e = q.pop_front();
                        chk("sb_kind_done", e.is_done, 1);
                    end
                end
                st_prev = bus.o_rk_valid && !bus.i_rk_ready;
                p_rk = bus.o_rk;
                p_idx = bus.o_rk_idx;
                p_last = bus.o_rk_last;
            end else begin
                st_prev = 1'b0;
            end
        end
    end

    localparam logic [79:0] KA = 80'h0123_4567_89AB_CDEF_1357;
    localparam logic [79:0] KB = 80'hDEAD_BEEF_0000_1111_2222;
    localparam logic [79:0] KC = 80'h5A5A_0F0F_C3C3_9696_A5A5;

    initial begin
        int n;
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.i_start = 1'b0;
        bus.i_key = '0;
        bus.i_rk_ready = 1'b0;
        #2;
        chk_zero("reset");
        tick();
        tick();
        rst = 1'b1;
        bus.i_rk_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_valid", bus.o_rk_valid, 0);
            chk("idle_busy", bus.o_busy, 0);
            chk("idle_done", bus.o_done, 0);
            chk("idle_rk", bus.o_rk, 0);
        end

        // Zero key, ready held high
        push_run(80'h0);
        start_run(80'h0);
        chk("z_valid0", bus.o_rk_valid, 1);
        chk("z_busy0", bus.o_busy, 1);
        chk("z_rk0", bus.o_rk, 64'h0);
        chk("z_idx0", bus.o_rk_idx, 0);
        tick();
        chk("z_rk1", bus.o_rk, 64'h0800_0000_0000_000E);
        chk("z_idx1", bus.o_rk_idx, 1);
        wait_done(60, n);
        chk("z_done_lat", n, 25);
        tick();
        chk("z_done_pulse", bus.o_done, 0);
        chk("z_idle_busy", bus.o_busy, 0);

        // Zero key, random ready
        bus.i_rk_ready = 1'b0;
        push_run(80'h0);
        start_run(80'h0);
        n = 0;
        while (!bus.o_done && n < 600) begin
            bus.i_rk_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        chk("rnd_done", bus.o_done, 1);
        bus.i_rk_ready = 1'b1;
        tick();

        // Start pulsed mid-run is ignored
        push_run(KA);
        start_run(KA);
        wait_idx(5'd10, 40, "ign_idx10");
        bus.i_key = KB;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        wait_done(60, n);
        chk("ign_done", bus.o_done, 1);
        tick();
        tick();
        tick();
        chk("ign_no_queue_busy", bus.o_busy, 0);
        chk("ign_no_queue_valid", bus.o_rk_valid, 0);

        // Reset mid-run
        push_run(KB);
        start_run(KB);
        wait_idx(5'd12, 40, "rst_idx12");
        rst = 1'b0;
        q.delete();
        #1;
        chk_zero("rst_mid");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_hold_done", bus.o_done, 0);
            chk("rst_hold_valid", bus.o_rk_valid, 0);
        end
        rst = 1'b1;
        tick();
        chk("rst_after_done", bus.o_done, 0);
        push_run({80{1'b1}});
        start_run({80{1'b1}});
        chk("rst_new_rk0", bus.o_rk, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_new_idx0", bus.o_rk_idx, 0);
        wait_done(60, n);
        chk("rst_new_done", bus.o_done, 1);
        tick();

        // Back-to-back with start held high
        push_run(KC);
        push_run(KC);
        bus.i_key = KC;
        bus.i_start = 1'b1;
        tick();
        wait_done(60, n);
        chk("b2b_done1", bus.o_done, 1);
        tick();
        chk("b2b_idle_busy", bus.o_busy, 0);
        chk("b2b_idle_valid", bus.o_rk_valid, 0);
        tick();
        chk("b2b_rk0_valid", bus.o_rk_valid, 1);
        chk("b2b_rk0_idx", bus.o_rk_idx, 0);
        chk("b2b_rk0", bus.o_rk, KC[63:0]);
        bus.i_start = 1'b0;
        wait_done(60, n);
        chk("b2b_done2", bus.o_done, 1);
        tick();
        tick();
        chk("b2b_end_busy", bus.o_busy, 0);

        chk("sb_drain", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
